// File: rtl/eq_arith_core.sv
// eq_arith_core: OFDM equalizer arithmetic -- LTS mean and pipelined complex normalisation.
// Define EQ_MEAN_EN to build the LTS mean path; otherwise mean_c/mean_out_stb are tied to 0.

module eq_div_lane #(
  parameter int W  = 32,
  parameter int DW = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [W-1:0]  quotient
);
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

  // acc[k] holds the not-yet-consumed dividend bits on top, quotient bits shifted in below
  logic [W:0][W-1:0]    acc;
  logic [W:0]           neg;
  logic [W-1:0][DW-1:0] rem;
  logic [W-1:0][DW-1:0] dsr;
  logic [W-1:0][DW:0]   trial;
  logic [W-1:0]         ge;
  logic [W-1:0]         mag;
  logic                 unused_trial;

  assign mag          = dividend[W-1] ? (~dividend + W'(1)) : dividend;
  assign unused_trial = ^trial;

  always_comb begin
    trial = '0;
    ge    = '0;
    for (int k = 0; k < W; k++) begin
      ge[k]    = {rem[k], acc[k][W-1]} >= {1'b0, dsr[k]};
      trial[k] = ge[k] ? ({rem[k], acc[k][W-1]} - {1'b0, dsr[k]}) : {rem[k], acc[k][W-1]};
    end
  end

  // A zero divisor yields an all-ones quotient, which lands in the saturation branch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      neg      <= '0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
    end else if (enable) begin
      acc[0] <= mag;
      neg[0] <= dividend[W-1];
      rem[0] <= '0;
      dsr[0] <= divisor;
      for (int k = 0; k < W; k++) begin
        acc[k+1] <= {acc[k][W-2:0], ge[k]};
        neg[k+1] <= neg[k];
      end
      for (int k = 0; k < W-1; k++) begin
        rem[k+1] <= trial[k][DW-1:0];
        dsr[k+1] <= dsr[k];
      end
      if (acc[W][W-1]) quotient <= neg[W] ? SAT_NEG : SAT_POS;
      else             quotient <= neg[W] ? (~acc[W] + W'(1)) : acc[W];
    end
  end
endmodule

module eq_arith_core #(
  parameter int SCALE_SHIFT = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] mean_a,
  input  logic [15:0] mean_b,
  input  logic        mean_sign,
  input  logic        mean_in_stb,
  output logic [15:0] mean_c,
  output logic        mean_out_stb,
  input  logic [15:0] s_i,
  input  logic [15:0] s_q,
  input  logic [15:0] l_i,
  input  logic [15:0] l_q,
  input  logic        norm_in_stb,
  output logic [31:0] norm_i,
  output logic [31:0] norm_q,
  output logic        norm_out_stb
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;
  localparam int DIV_W     = 24;
  localparam int STAGES    = VEC_W + 4;

  logic [VEC_W-1:0] si_x, sq_x, li_x, lq_x;
  logic [VEC_W-1:0] m_ii, m_qq, m_qi, m_iq, m_li, m_lq;
  logic [VEC_W-1:0] mag2;
  logic [NUM_LANES-1:0][VEC_W-1:0] prod, dvd, quot;
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  logic             unused_mag;

  // Unsigned 32-bit products of sign-extended operands give the wrapped two's-complement result
  assign si_x       = {{16{s_i[15]}}, s_i};
  assign sq_x       = {{16{s_q[15]}}, s_q};
  assign li_x       = {{16{l_i[15]}}, l_i};
  assign lq_x       = {{16{l_q[15]}}, l_q};
  assign vld_pipe   = {vld_q, norm_in_stb};
  assign unused_mag = ^mag2[VEC_W-1:DIV_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ii  <= '0;
      m_qq  <= '0;
      m_qi  <= '0;
      m_iq  <= '0;
      m_li  <= '0;
      m_lq  <= '0;
      prod  <= '0;
      mag2  <= '0;
      vld_q <= '0;
    end else if (enable) begin
      m_ii    <= si_x * li_x;
      m_qq    <= sq_x * lq_x;
      m_qi    <= sq_x * li_x;
      m_iq    <= si_x * lq_x;
      m_li    <= li_x * li_x;
      m_lq    <= lq_x * lq_x;
      prod[0] <= m_ii + m_qq;
      prod[1] <= m_qi - m_iq;
      mag2    <= m_li + m_lq;
      vld_q   <= vld_pipe[STAGES-1:0];
    end
  end

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign dvd[g] = prod[g] << SCALE_SHIFT;
      eq_div_lane #(.W(VEC_W), .DW(DIV_W)) u_div (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .dividend (dvd[g]),
        .divisor  (mag2[DIV_W-1:0]),
        .quotient (quot[g])
      );
    end
  endgenerate

  assign norm_i       = quot[0];
  assign norm_q       = quot[1];
  assign norm_out_stb = vld_pipe[STAGES] & enable;

`ifdef EQ_MEAN_EN
  logic [16:0] mean_sum;
  logic [15:0] mean_q;
  logic        mean_vld;
  logic        unused_mean;

  assign mean_sum    = mean_sign ? ({mean_a[15], mean_a} - {mean_b[15], mean_b})
                                 : ({mean_a[15], mean_a} + {mean_b[15], mean_b});
  assign unused_mean = mean_sum[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mean_q   <= '0;
      mean_vld <= 1'b0;
    end else if (enable) begin
      mean_vld <= mean_in_stb;
      if (mean_in_stb) mean_q <= mean_sum[16:1];
    end
  end

  assign mean_c       = mean_q;
  assign mean_out_stb = mean_vld & enable;
`else
  logic unused_mean;
  assign unused_mean  = ^{mean_a, mean_b, mean_sign, mean_in_stb};
  assign mean_c       = '0;
  assign mean_out_stb = 1'b0;
`endif
endmodule

// File: tb/tb_eq_arith_core.sv
// Bench for eq_arith_core: norm results go through a queue scoreboard stamped with the
// expected enabled-cycle of arrival; mean results are checked one cycle after each strobe.

module tb_eq_arith_core;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] mean_a = '0, mean_b = '0;
  logic        mean_sign = 1'b0, mean_in_stb = 1'b0;
  logic [15:0] mean_c;
  logic        mean_out_stb;
  logic [15:0] s_i = '0, s_q = '0, l_i = '0, l_q = '0;
  logic        norm_in_stb = 1'b0;
  logic [31:0] norm_i, norm_q;
  logic        norm_out_stb;

  typedef struct { logic [31:0] i; logic [31:0] q; int cyc; } rec_t;
  rec_t obs [256];
  rec_t exp_q [$];
  int   obs_wr = 0, obs_rd = 0, en_cyc = 0;
  int   n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  eq_arith_core #(.SCALE_SHIFT(11)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .mean_a(mean_a), .mean_b(mean_b), .mean_sign(mean_sign), .mean_in_stb(mean_in_stb),
    .mean_c(mean_c), .mean_out_stb(mean_out_stb),
    .s_i(s_i), .s_q(s_q), .l_i(l_i), .l_q(l_q), .norm_in_stb(norm_in_stb),
    .norm_i(norm_i), .norm_q(norm_q), .norm_out_stb(norm_out_stb)
  );

  // Monitor: count enabled edges and record every norm output with its arrival stamp
  always @(posedge clock) begin
    if (enable && reset) en_cyc = en_cyc + 1;
    #1;
    if (norm_out_stb === 1'b1) begin
      obs[obs_wr % 256] = '{norm_i, norm_q, en_cyc};
      obs_wr = obs_wr + 1;
    end
  end

  function automatic logic [31:0] mdiv(input int dvd, input int dsr);
    longint q;
    if (dsr == 0) return (dvd >= 0) ? 32'h7FFFFFFF : 32'h80000001;
    q = longint'(dvd) / longint'(dsr);
    if (q > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (q < -64'sd2147483647) return 32'h80000001;
    return q[31:0];
  endfunction

  function automatic rec_t model(input int si, input int sq, input int li, input int lq);
    int   pi, pq, m, d;
    rec_t r;
    pi  = si * li + sq * lq;
    pq  = sq * li - si * lq;
    m   = li * li + lq * lq;
    d   = m & 32'h00FFFFFF;
    r.i = mdiv(pi <<< 11, d);
    r.q = mdiv(pq <<< 11, d);
    r.cyc = 0;
    return r;
  endfunction

  task automatic push_norm(input logic [15:0] si, input logic [15:0] sq,
                           input logic [15:0] li, input logic [15:0] lq);
    rec_t e;
    @(negedge clock);
    s_i = si; s_q = sq; l_i = li; l_q = lq;
    norm_in_stb = 1'b1;
    e = model(int'($signed(si)), int'($signed(sq)), int'($signed(li)), int'($signed(lq)));
    e.cyc = en_cyc + 36;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      norm_in_stb = 1'b0;
      mean_in_stb = 1'b0;
    end
  endtask

  task automatic collect(output bit ok);
    int b;
    b = 0;
    while (obs_wr < obs_rd + exp_q.size() && b < 400) begin
      @(negedge clock);
      b++;
    end
    ok = (obs_wr >= obs_rd + exp_q.size());
  endtask

  task automatic test_reset;
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++; if (norm_i !== 32'h0)     begin n_err++; $display("FAIL reset_norm_i: got %h want 0", norm_i); end
    n_cmp++; if (norm_q !== 32'h0)     begin n_err++; $display("FAIL reset_norm_q: got %h want 0", norm_q); end
    n_cmp++; if (norm_out_stb !== 1'b0) begin n_err++; $display("FAIL reset_norm_stb: got %b want 0", norm_out_stb); end
    n_cmp++; if (mean_c !== 16'h0)     begin n_err++; $display("FAIL reset_mean_c: got %h want 0", mean_c); end
    n_cmp++; if (mean_out_stb !== 1'b0) begin n_err++; $display("FAIL reset_mean_stb: got %b want 0", mean_out_stb); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_mean;
    logic [15:0] va [5] = '{16'd100, 16'd100, 16'hFFFD, 16'h7FFF, 16'h8000};
    logic [15:0] vb [5] = '{16'hFFD8, 16'hFFD8, 16'h0000, 16'h7FFF, 16'h7FFF};
    logic        vs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] vc [5] = '{16'd30, 16'd70, 16'hFFFE, 16'h7FFF, 16'h8000};
    logic [15:0] ec;
    logic        es;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      mean_a = va[n]; mean_b = vb[n]; mean_sign = vs[n]; mean_in_stb = 1'b1;
      @(posedge clock); #1;
`ifdef EQ_MEAN_EN
      ec = vc[n]; es = 1'b1;
`else
      ec = 16'h0; es = 1'b0;
`endif
      n_cmp++; if (mean_c !== ec)       begin n_err++; $display("FAIL mean_c[%0d]: got %h want %h", n, mean_c, ec); end
      n_cmp++; if (mean_out_stb !== es) begin n_err++; $display("FAIL mean_stb[%0d]: got %b want %b", n, mean_out_stb, es); end
    end
    @(negedge clock);
    mean_in_stb = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (mean_out_stb !== 1'b0) begin n_err++; $display("FAIL mean_stb_idle: got %b want 0", mean_out_stb); end
    // Result captured, then enable dropped: strobe masked, value held, strobe back on re-enable
    @(negedge clock);
    mean_a = va[0]; mean_b = vb[0]; mean_sign = vs[0]; mean_in_stb = 1'b1;
    @(negedge clock);
    mean_in_stb = 1'b0; enable = 1'b0;
    @(posedge clock); #1;
`ifdef EQ_MEAN_EN
    ec = vc[0]; es = 1'b1;
`else
    ec = 16'h0; es = 1'b0;
`endif
    n_cmp++; if (mean_out_stb !== 1'b0) begin n_err++; $display("FAIL mean_hold_stb: got %b want 0", mean_out_stb); end
    n_cmp++; if (mean_c !== ec)         begin n_err++; $display("FAIL mean_hold_c: got %h want %h", mean_c, ec); end
    @(negedge clock);
    enable = 1'b1;
    #1;
    n_cmp++; if (mean_out_stb !== es)   begin n_err++; $display("FAIL mean_resume_stb: got %b want %b", mean_out_stb, es); end
    idle(2);
  endtask

  task automatic test_norm;
    logic [15:0] tab [6][4] = '{
      '{16'd1000, 16'd0,    16'd1000, 16'd0},
      '{16'd0,    16'd500,  16'd0,    16'hFE0C},
      '{16'hFFFF, 16'd0,    16'd3,    16'd0},
      '{16'd5,    16'd5,    16'd0,    16'd0},
      '{16'hFFFF, 16'd1,    16'd4096, 16'd0},
      '{16'd0,    16'hFF00, 16'd1,    16'd4096}};
    rec_t e, o;
    bit   ok;
    for (int n = 0; n < 6; n++) push_norm(tab[n][0], tab[n][1], tab[n][2], tab[n][3]);
    idle(1);
    collect(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL norm_count: got %0d outputs want %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs[obs_rd % 256]; obs_rd++;
      n_cmp++;
      if (o.i !== e.i || o.q !== e.q || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL norm_data: got %h/%h @%0d want %h/%h @%0d", o.i, o.q, o.cyc, e.i, e.q, e.cyc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    rec_t e, o;
    bit   ok;
    for (int n = 0; n < 64; n++)
      push_norm(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    idle(1);
    collect(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_count: got %0d outputs want %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs[obs_rd % 256]; obs_rd++;
      n_cmp++;
      if (o.i !== e.i || o.q !== e.q || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL b2b_data: got %h/%h @%0d want %h/%h @%0d", o.i, o.q, o.cyc, e.i, e.q, e.cyc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_enable;
    rec_t e, o;
    bit   ok;
    for (int n = 0; n < 10; n++)
      push_norm(16'($urandom_range(0, 2000)), 16'($urandom()), 16'($urandom_range(1, 3000)), 16'($urandom()));
    @(negedge clock);
    norm_in_stb = 1'b0; enable = 1'b0;
    repeat (10) @(negedge clock);
    enable = 1'b1;
    for (int n = 0; n < 10; n++)
      push_norm(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    idle(22);
    // Outputs are due during this pause; the strobe must stay masked
    @(negedge clock);
    enable = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      n_cmp++; if (norm_out_stb !== 1'b0) begin n_err++; $display("FAIL enable_mask: got %b want 0", norm_out_stb); end
    end
    @(negedge clock);
    enable = 1'b1;
    collect(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL enable_count: got %0d outputs want %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs[obs_rd % 256]; obs_rd++;
      n_cmp++;
      if (o.i !== e.i || o.q !== e.q || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL enable_data: got %h/%h @%0d want %h/%h @%0d", o.i, o.q, o.cyc, e.i, e.q, e.cyc);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    rec_t e, o;
    bit   ok;
    int   base;
    for (int n = 0; n < 10; n++)
      push_norm(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    idle(15);
    reset = 1'b0;
    #1;
    n_cmp++; if (norm_i !== 32'h0)      begin n_err++; $display("FAIL midrst_norm_i: got %h want 0", norm_i); end
    n_cmp++; if (norm_q !== 32'h0)      begin n_err++; $display("FAIL midrst_norm_q: got %h want 0", norm_q); end
    n_cmp++; if (norm_out_stb !== 1'b0) begin n_err++; $display("FAIL midrst_stb: got %b want 0", norm_out_stb); end
    n_cmp++; if (mean_c !== 16'h0)      begin n_err++; $display("FAIL midrst_mean_c: got %h want 0", mean_c); end
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    base = obs_wr;
    idle(60);
    n_cmp++; if (obs_wr !== base) begin n_err++; $display("FAIL midrst_stale: got %0d outputs want 0", obs_wr - base); end
    obs_rd = obs_wr;
    push_norm(16'd1000, 16'd0, 16'd1000, 16'd0);
    idle(1);
    collect(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL midrst_count: got %0d outputs want %0d", obs_wr - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front(); o = obs[obs_rd % 256]; obs_rd++;
      n_cmp++;
      if (o.i !== 32'd2048 || o.q !== 32'd0 || o.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL midrst_data: got %h/%h @%0d want %h/%h @%0d", o.i, o.q, o.cyc, 32'd2048, 32'd0, e.cyc);
      end
    end
    exp_q.delete();
    idle(40);
    n_cmp++; if (obs_wr !== obs_rd) begin n_err++; $display("FAIL spurious_out: got %0d extra outputs want 0", obs_wr - obs_rd); end
  endtask

  initial begin
    test_reset;
    test_mean;
    test_norm;
    test_back_to_back;
    test_enable;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
